// File: rtl/keccak_arbiter.sv
// keccak_arbiter: shares one keccak core between two message sources.
//   Grants the core round-robin, pulses the core reset once per message, forwards the owner's
//   32-bit word stream under k_buffer_full back-pressure, then captures the 512-bit digest and
//   holds it, tagged with the owner id, until digest_ack.
// Optional feature: define KECCAK_ARB_TIMEOUT_EN to abort a message whose digest does not appear
//   within TIMEOUT_CYC cycles of the last word (digest=0, digest_err=1).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req[1:0]                    per-source request, held until its digest is accepted
//   in0/in1, in_ready0/1,
//   is_last0/1, byte_num0/1     source word streams
//   gnt[1:0], ack[1:0]          one-hot grant, per-source word accept (combinational)
//   k_*                         core interface (reset, word stream, buffer_full, out, out_ready)
//   digest, digest_valid,
//   digest_id, digest_err,
//   digest_ack                  digest result handshake
module keccak_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CNT_W       = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [31:0]  in0,
  input  logic [31:0]  in1,
  input  logic         in_ready0,
  input  logic         in_ready1,
  input  logic         is_last0,
  input  logic         is_last1,
  input  logic [1:0]   byte_num0,
  input  logic [1:0]   byte_num1,
  output logic [1:0]   gnt,
  output logic [1:0]   ack,
  output logic         k_reset,
  output logic [31:0]  k_in,
  output logic         k_in_ready,
  output logic         k_is_last,
  output logic [1:0]   k_byte_num,
  input  logic         k_buffer_full,
  input  logic [511:0] k_out,
  input  logic         k_out_ready,
  output logic [511:0] digest,
  output logic         digest_valid,
  output logic         digest_id,
  output logic         digest_err,
  input  logic         digest_ack
);

  // StAbort and StTmo are the single k_reset cycles of the abort and timeout paths.
  typedef enum logic [2:0] {StIdle, StRst, StFeed, StWait, StDone, StAbort, StTmo} state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           rr_last_q, rr_last_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [511:0]   digest_q, digest_d;
  logic           digest_valid_q, digest_valid_d;
  logic           digest_id_q, digest_id_d;

  // Owner-side view of the two sources.
  logic        own_req, own_rdy, own_last;
  logic [31:0] own_in;
  logic [1:0]  own_bn;

  assign own_req  = owner_q ? req[1]    : req[0];
  assign own_rdy  = owner_q ? in_ready1 : in_ready0;
  assign own_last = owner_q ? is_last1  : is_last0;
  assign own_in   = owner_q ? in1       : in0;
  assign own_bn   = owner_q ? byte_num1 : byte_num0;

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_last_d      = rr_last_q;
    gnt_d          = gnt_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    digest_id_d    = digest_id_q;
`ifdef KECCAK_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    err_d          = err_q;
`endif
    ack            = 2'b00;
    k_in_ready     = 1'b0;
    k_in           = '0;
    k_is_last      = 1'b0;
    k_byte_num     = '0;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          // Contended grant goes to the source not served last.
          owner_d = (req == 2'b11) ? ~rr_last_q : req[1];
          gnt_d   = owner_d ? 2'b10 : 2'b01;
          state_d = StRst;
        end
      end
      StRst: state_d = StFeed;
      StFeed: begin
        if (!own_req) begin
          // Owner withdrew mid-message: drop it and reset the core on the way out.
          rr_last_d = owner_q;
          gnt_d     = 2'b00;
          state_d   = StAbort;
        end else if (own_rdy && !k_buffer_full) begin
          ack        = owner_q ? 2'b10 : 2'b01;
          k_in_ready = 1'b1;
          k_in       = own_in;
          k_is_last  = own_last;
          k_byte_num = own_bn;
          if (own_last) begin
            state_d = StWait;
`ifdef KECCAK_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StWait: begin
        if (k_out_ready) begin
          digest_d       = k_out;
          digest_id_d    = owner_q;
          digest_valid_d = 1'b1;
          state_d        = StDone;
`ifdef KECCAK_ARB_TIMEOUT_EN
          err_d          = 1'b0;
        end else if (cnt_q == CntLast) begin
          digest_d       = '0;
          digest_id_d    = owner_q;
          digest_valid_d = 1'b1;
          err_d          = 1'b1;
          state_d        = StTmo;
        end else begin
          cnt_d          = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        if (digest_ack) begin
          digest_valid_d = 1'b0;
          rr_last_d      = owner_q;
          gnt_d          = 2'b00;
          state_d        = StIdle;
        end
      end
      StAbort: state_d = StIdle;
      StTmo:   state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      owner_q        <= 1'b0;
      rr_last_q      <= 1'b1;
      gnt_q          <= 2'b00;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      digest_id_q    <= 1'b0;
`ifdef KECCAK_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_last_q      <= rr_last_d;
      gnt_q          <= gnt_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      digest_id_q    <= digest_id_d;
`ifdef KECCAK_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign k_reset      = reset | (state_q inside {StRst, StAbort, StTmo});
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign digest_id    = digest_id_q;

`ifdef KECCAK_ARB_TIMEOUT_EN
  assign digest_err = err_q;
`else
  // No timeout path: zero for any counter width able to hold TIMEOUT_CYC.
  localparam bit CfgOk = CNT_W >= $clog2(TIMEOUT_CYC + 1);
  assign digest_err = digest_valid_q & ~CfgOk;
`endif

endmodule

// File: tb/tb_keccak_arbiter.sv
// Testbench for keccak_arbiter: two randomized message sources, a behavioural core model whose
// digest is an order-sensitive fold of every word it receives, and a scoreboard of expected
// {id, digest, err} results checked by an independent monitor.
module tb_keccak_arbiter;

  localparam int unsigned To = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [31:0]  in0, in1;
  logic         in_ready0, in_ready1, is_last0, is_last1;
  logic [1:0]   byte_num0, byte_num1;
  logic [1:0]   gnt, ack;
  logic         k_reset, k_in_ready, k_is_last;
  logic [31:0]  k_in;
  logic [1:0]   k_byte_num;
  logic         k_buffer_full;
  logic [511:0] k_out;
  logic         k_out_ready;
  logic [511:0] digest;
  logic         digest_valid, digest_id, digest_err, digest_ack;

  always #5 clk = ~clk;

  keccak_arbiter #(.TIMEOUT_CYC(To), .CNT_W(13)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in0(in0), .in1(in1), .in_ready0(in_ready0), .in_ready1(in_ready1),
    .is_last0(is_last0), .is_last1(is_last1), .byte_num0(byte_num0), .byte_num1(byte_num1),
    .gnt(gnt), .ack(ack), .k_reset(k_reset), .k_in(k_in), .k_in_ready(k_in_ready),
    .k_is_last(k_is_last), .k_byte_num(k_byte_num), .k_buffer_full(k_buffer_full),
    .k_out(k_out), .k_out_ready(k_out_ready), .digest(digest), .digest_valid(digest_valid),
    .digest_id(digest_id), .digest_err(digest_err), .digest_ack(digest_ack)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Entry format: {is_last, byte_num[1:0], word[31:0]}
  logic [34:0]  q0[$], q1[$], stage[$];
  logic         exp_id[$], exp_err[$];
  logic [511:0] exp_dig[$];

  bit [1:0] wait_dig, dig_done;
  int       sent[2], drop_at[2];
  bit       do_reset, rst_pulse, hold_out, rand_full, model_rr;
  int       force_full, dv_rises, t_wait;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_sim;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Order-sensitive fold of a word stream into 512 bits.
  function automatic logic [511:0] hstep(input logic [511:0] h, input logic [34:0] e,
                                         input int idx);
    return {h[478:0], h[511:479]} ^ {477'(idx + 1), e};
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [34:0] qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [34:0] qpop(input int i);
    return (i == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic flush(input int i);
    logic [34:0] e;
    e = '0;
    while (qsize(i) > 0 && !e[34]) e = qpop(i);
  endtask

  task automatic stage_str(input string s);
    int n, nw;
    logic [31:0] w;
    n  = s.len();
    nw = n / 4 + 1;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) w[31-8*j -: 8] = (4*k + j < n) ? s[4*k + j] : 8'h00;
      stage.push_back({(k == nw - 1), 2'(n % 4), w});
    end
  endtask

  task automatic stage_rand(input int nw);
    for (int k = 0; k < nw; k++)
      stage.push_back({(k == nw - 1), (k == nw - 1) ? 2'($urandom_range(3)) : 2'b00,
                       32'($urandom())});
  endtask

  // mode 0: no digest expected, 1: normal digest, 2: timeout result
  task automatic commit(input int src, input int mode);
    logic [511:0] h;
    h = '0;
    for (int k = 0; k < stage.size(); k++) begin
      h = hstep(h, stage[k], k);
      if (src == 0) q0.push_back(stage[k]); else q1.push_back(stage[k]);
    end
    if (mode != 0) begin
      exp_id.push_back(src[0]);
      exp_dig.push_back((mode == 2) ? 512'd0 : h);
      exp_err.push_back(mode == 2);
    end
    stage.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(exp_id.size() == 0 && q0.size() == 0 && q1.size() == 0 && wait_dig == 2'b00 &&
             req == 2'b00 && gnt == 2'b00 && !do_reset && !rst_pulse)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy after %0d cycles expected idle", budget);
        finish_sim();
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Core model
  initial begin
    logic        s_kr, s_kv, s_full;
    logic [34:0] s_e;
    logic [511:0] ch;
    int cidx, lat;
    ch = '0; cidx = 0; lat = -1;
    k_buffer_full = 1'b0; k_out = '0; k_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      s_kr = k_reset; s_kv = k_in_ready; s_full = k_buffer_full;
      s_e  = {k_is_last, k_byte_num, k_in};
      @(posedge clk); #1;
      if (s_kr) begin
        ch = '0; cidx = 0; lat = -1; k_out_ready = 1'b0; k_out = '0;
      end else begin
        if (s_kv && !s_full) begin
          ch = hstep(ch, s_e, cidx);
          cidx++;
          if (s_e[34]) lat = $urandom_range(6);
        end
        if (lat == 0 && !hold_out) begin
          k_out_ready = 1'b1; k_out = ch; lat = -1;
        end else if (lat > 0) lat--;
      end
      k_buffer_full = (force_full > 0) || (rand_full && $urandom_range(5) == 0);
      if (force_full > 0) force_full--;
    end
  end

  // Source driver
  initial begin
    logic [1:0]  s_ack, s_gnt;
    logic [34:0] e;
    bit          show;
    forever begin
      @(negedge clk);
      s_ack = ack; s_gnt = gnt;
      @(posedge clk); #1;
      if (rst_pulse) begin reset = 1'b0; rst_pulse = 1'b0; end
      for (int i = 0; i < 2; i++) begin
        if (s_ack[i]) begin
          e = qpop(i);
          sent[i]++;
          if (e[34]) begin wait_dig[i] = 1'b1; sent[i] = 0; end
        end
        if (drop_at[i] > 0 && sent[i] == drop_at[i]) begin
          flush(i); req[i] = 1'b0; drop_at[i] = 0; sent[i] = 0;
        end else if (wait_dig[i] && dig_done[i]) begin
          req[i] = 1'b0; wait_dig[i] = 1'b0; dig_done[i] = 1'b0;
        end else if (!req[i] && !wait_dig[i] && qsize(i) > 0) begin
          req[i] = 1'b1;
        end
      end
      if (do_reset) begin
        do_reset = 1'b0; reset = 1'b1; rst_pulse = 1'b1;
        for (int i = 0; i < 2; i++)
          if (s_gnt[i] && !wait_dig[i]) begin flush(i); req[i] = 1'b0; sent[i] = 0; end
      end
      for (int i = 0; i < 2; i++) begin
        show = req[i] && !wait_dig[i] && qsize(i) > 0 && $urandom_range(3) != 0;
        e = show ? qfront(i) : 35'd0;
        if (i == 0) begin
          in0 = e[31:0]; byte_num0 = e[33:32]; is_last0 = e[34]; in_ready0 = show;
        end else begin
          in1 = e[31:0]; byte_num1 = e[33:32]; is_last1 = e[34]; in_ready1 = show;
        end
      end
      digest_ack = ($urandom_range(2) == 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [1:0] prev_gnt;
    logic prev_dv, prev_kor, eid, eerr;
    logic [511:0] edig;
    prev_gnt = 2'b00; prev_dv = 1'b0; prev_kor = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (gnt != 2'b00) chk("gnt_onehot", 512'(gnt == 2'b01 || gnt == 2'b10), 512'd1);
        if (gnt != 2'b00 && prev_gnt == 2'b00)
          chk("grant_core_reset", 512'({k_reset, k_in_ready}), 512'(2'b10));
        if (k_buffer_full) chk("ack_when_full", 512'(ack), 512'd0);
        if (ack != 2'b00) chk("ack_to_owner", 512'(ack & ~gnt), 512'd0);
        if (ack != 2'b00 && k_is_last) t_wait = cyc + 1;
        if (digest_valid && !prev_dv) begin
          dv_rises++;
`ifdef KECCAK_ARB_TIMEOUT_EN
          if (digest_err) chk("timeout_latency", 512'(cyc - t_wait), 512'(To));
          else chk("dv_after_out_ready", 512'(prev_kor), 512'd1);
`else
          chk("dv_after_out_ready", 512'(prev_kor), 512'd1);
`endif
        end
        if (digest_valid && digest_ack) begin
          if (exp_id.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_digest: got id %0d expected no digest", digest_id);
          end else begin
            eid = exp_id.pop_front(); edig = exp_dig.pop_front(); eerr = exp_err.pop_front();
            chk("digest_id", 512'(digest_id), 512'(eid));
            chk("digest_err", 512'(digest_err), 512'(eerr));
            chk("digest", digest, edig);
          end
          dig_done[digest_id] = 1'b1;
        end
      end
      prev_gnt = gnt; prev_dv = digest_valid; prev_kor = k_out_ready;
    end
  end

  initial begin
    #900000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    finish_sim();
  end

  initial begin
    int first, n, c0;
    reset = 1'b1; req = 2'b00; digest_ack = 1'b0;
    in0 = '0; in1 = '0; in_ready0 = 1'b0; in_ready1 = 1'b0;
    is_last0 = 1'b0; is_last1 = 1'b0; byte_num0 = '0; byte_num1 = '0;
    wait_dig = '0; dig_done = '0; sent = '{0, 0}; drop_at = '{0, 0};
    do_reset = 1'b0; rst_pulse = 1'b0; hold_out = 1'b0; rand_full = 1'b0;
    force_full = 0; dv_rises = 0; t_wait = 0; model_rr = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 512'(gnt), 512'd0);
    chk("rst_ack", 512'(ack), 512'd0);
    chk("rst_digest_valid", 512'(digest_valid), 512'd0);
    chk("rst_digest", digest, 512'd0);
    chk("rst_id_err", 512'({digest_id, digest_err}), 512'd0);
    chk("rst_k_reset", 512'(k_reset), 512'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("k_reset_idle", 512'(k_reset), 512'd0);

    // Simultaneous requests, identical messages: source 0 first out of reset.
    stage_str("Hello, world!"); commit(0, 1);
    stage_str("Hello, world!"); commit(1, 1);
    wait_idle(2000); model_rr = 1'b1;

    stage_str("The quick brown fox jumps over the lazy dog"); commit(0, 1);
    wait_idle(2000); model_rr = 1'b0;

    stage_str(""); commit(1, 1);
    wait_idle(2000); model_rr = 1'b1;

    // Forced stall mid-message, then the same message unstalled.
    stage_str("Lorem ipsum dolor sit amet, consectetur adipiscing elit s."); commit(0, 1);
    n = 0;
    while (sent[0] < 5 && n < 2000) begin @(negedge clk); n++; end
    force_full = 5;
    wait_idle(2000);
    stage_str("Lorem ipsum dolor sit amet, consectetur adipiscing elit s."); commit(0, 1);
    wait_idle(2000); model_rr = 1'b0;

    // Source 0 withdraws after 3 words, then a reset lands mid-message.
    drop_at[0] = 3;
    stage_str("Lorem ipsum dolor sit amet, consectetur adipiscing elit s."); commit(0, 0);
    wait_idle(2000);
    stage_str("The quick brown fox jumps over the lazy dog"); commit(0, 0);
    n = 0;
    while (sent[0] < 2 && n < 2000) begin @(negedge clk); n++; end
    do_reset = 1'b1;
    wait_idle(2000); model_rr = 1'b1;
    stage_str("Hello, world!"); commit(1, 1);
    wait_idle(2000); model_rr = 1'b1;

    // Both sources loaded at once: grants alternate starting with the one not served last.
    rand_full = 1'b1;
    first = model_rr ? 0 : 1;
    for (int k = 0; k < 4; k++) begin
      stage_rand($urandom_range(1, 12)); commit(first, 1);
      stage_rand($urandom_range(1, 12)); commit(1 - first, 1);
    end
    wait_idle(20000);
    rand_full = 1'b0;

    // Core never reports a digest.
    hold_out = 1'b1;
`ifdef KECCAK_ARB_TIMEOUT_EN
    stage_str("The quick brown fox jumps over the lazy dog"); commit(0, 2);
    wait_idle(2000);
    hold_out = 1'b0;
`else
    stage_str("The quick brown fox jumps over the lazy dog"); commit(0, 1);
    c0 = dv_rises;
    repeat (1000) @(negedge clk);
    chk("no_digest_while_waiting", 512'(dv_rises - c0), 512'd0);
    chk("still_granted", 512'(gnt), 512'(2'b01));
    hold_out = 1'b0;
    wait_idle(2000);
`endif

    finish_sim();
  end

endmodule
